// File: rtl/random_offset_gen.sv
// Fills the per-log X/Y start-offset table from a 16-bit Galois LFSR, one entry per clock.
// Build option: RANDOM_OFFSET_FREERUN_EN makes the LFSR also step while IDLE/DONE.
module random_offset_gen #(
  parameter int                NUM_OF_LOGS = 15,
  parameter int                OFFSET_W    = 9,
  parameter int                LFSR_W      = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED        = 16'hACE1,
  parameter int                X_LIMIT     = 480,
  parameter int                Y_LIMIT     = 400
) (
  input  logic                                    CLK,
  input  logic                                    RESET,
  input  logic                                    regen_req,
  input  logic                                    seed_load,
  input  logic [LFSR_W-1:0]                       seed_in,
  output logic                                    busy,
  output logic                                    done,
  output logic [NUM_OF_LOGS-1:0][OFFSET_W-1:0]    start_offsetX,
  output logic [NUM_OF_LOGS-1:0][OFFSET_W-1:0]    start_offsetY
);

  localparam int                IDX_W = (NUM_OF_LOGS > 1) ? $clog2(NUM_OF_LOGS) : 1;
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NUM_OF_LOGS - 1);
  localparam logic [OFFSET_W:0] XL    = (OFFSET_W+1)'(X_LIMIT);
  localparam logic [OFFSET_W:0] YL    = (OFFSET_W+1)'(Y_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t                               r_state;
  logic [LFSR_W-1:0]                    r_lfsr;
  logic [IDX_W-1:0]                     r_idx;
  logic                                 r_phase;
  logic                                 r_busy;
  logic                                 r_done;
  logic [NUM_OF_LOGS-1:0][OFFSET_W-1:0] r_x;
  logic [NUM_OF_LOGS-1:0][OFFSET_W-1:0] r_y;

  logic [LFSR_W-1:0]   w_lfsr_nxt;
  logic [LFSR_W-1:0]   w_seed;
  logic [OFFSET_W-1:0] w_v;
  logic [OFFSET_W:0]   w_v_ext;
  logic [OFFSET_W-1:0] w_x;
  logic [OFFSET_W-1:0] w_y;

  assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
  assign w_seed     = (seed_in == '0) ? SEED : seed_in;

  // Offsets come from the post-step value; limits >= 256 so one subtract folds v into range.
  assign w_v     = w_lfsr_nxt[OFFSET_W-1:0];
  assign w_v_ext = {1'b0, w_v};
  assign w_x     = (w_v_ext >= XL) ? (w_v - XL[OFFSET_W-1:0]) : w_v;
  assign w_y     = (w_v_ext >= YL) ? (w_v - YL[OFFSET_W-1:0]) : w_v;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED;
      r_idx   <= '0;
      r_phase <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_done <= 1'b0;
      if (seed_load) begin
        r_lfsr  <= w_seed;
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_idx   <= '0;
        r_phase <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
`ifdef RANDOM_OFFSET_FREERUN_EN
            r_lfsr <= w_lfsr_nxt;
`endif
            if (regen_req) begin
              r_state <= S_FILL;
              r_busy  <= 1'b1;
              r_idx   <= '0;
              r_phase <= 1'b0;
            end
          end
          S_FILL: begin
            r_lfsr <= w_lfsr_nxt;
            if (!r_phase) begin
              r_x[r_idx] <= w_x;
              r_phase    <= 1'b1;
            end else begin
              r_y[r_idx] <= w_y;
              r_phase    <= 1'b0;
              if (r_idx == LAST) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
          end
          S_DONE: begin
`ifdef RANDOM_OFFSET_FREERUN_EN
            r_lfsr <= w_lfsr_nxt;
`endif
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign start_offsetX = r_x;
  assign start_offsetY = r_y;

endmodule

// File: tb/tb_random_offset_gen.sv
// Scoreboard bench for random_offset_gen: a behavioural LFSR model predicts each table.
module tb_random_offset_gen;
  localparam int N = 15;

  logic                  CLK = 1'b0;
  logic                  RESET, regen_req, seed_load;
  logic [15:0]           seed_in;
  logic                  busy, done;
  logic [N-1:0][8:0]     start_offsetX, start_offsetY;

  random_offset_gen dut (
    .CLK(CLK), .RESET(RESET), .regen_req(regen_req), .seed_load(seed_load),
    .seed_in(seed_in), .busy(busy), .done(done),
    .start_offsetX(start_offsetX), .start_offsetY(start_offsetY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [N-1:0][8:0] x;
    logic [N-1:0][8:0] y;
  } tbl_t;

  tbl_t              sb[$];
  logic [15:0]       m_lfsr;
  logic [N-1:0][8:0] m_x, m_y;
  int                n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic logic [8:0] wrapv(input logic [15:0] l, input int lim);
    int v;
    v = int'(l[8:0]);
    return (v >= lim) ? 9'(v - lim) : 9'(v);
  endfunction

  task automatic model_fill(input int nwr);
    for (int k = 0; k < nwr; k++) begin
      m_lfsr = lstep(m_lfsr);
      if (k % 2 == 0) m_x[k/2] = wrapv(m_lfsr, 480);
      else            m_y[k/2] = wrapv(m_lfsr, 400);
    end
  endtask

  task automatic model_reset;
    m_lfsr = 16'hACE1;
    m_x    = '0;
    m_y    = '0;
  endtask

  task automatic cmp_table(input string tag);
    tbl_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_X%0d", tag, i), start_offsetX[i], e.x[i]);
      chk($sformatf("%s_Y%0d", tag, i), start_offsetY[i], e.y[i]);
      chk($sformatf("%s_Xrng%0d", tag, i), int'(start_offsetX[i] < 9'd480), 1);
      chk($sformatf("%s_Yrng%0d", tag, i), int'(start_offsetY[i] < 9'd400), 1);
    end
  endtask

  task automatic fill_and_check(input string tag);
    int nb;
    bit got;
    model_fill(2*N);
    sb.push_back('{x: m_x, y: m_y});
    regen_req = 1'b1;
    tick;
    regen_req = 1'b0;
    nb = 0; got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done) begin got = 1'b1; break; end
      if (busy) nb++;
      tick;
    end
    chk({tag, "_busy_len"}, nb, 2*N);
    chk({tag, "_done_seen"}, int'(got), 1);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    cmp_table(tag);
    tick;
    chk({tag, "_done_1cyc"}, int'(done), 0);
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed_load = 1'b1; seed_in = s;
    tick;
    seed_load = 1'b0;
    m_lfsr = (s == 16'h0) ? 16'hACE1 : s;
  endtask

  initial begin
    int nd, c1, c2, nb;
    RESET = 1'b1; regen_req = 1'b0; seed_load = 1'b0; seed_in = '0;
    model_reset();
    tick; tick;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_X0", start_offsetX[0], 0);
    chk("rst_Y14", start_offsetY[N-1], 0);
    RESET = 1'b0;

    // Scenario 1: first fill from the reset seed
    fill_and_check("s1");
    chk("s1_X0_const", start_offsetX[0], 112);
    chk("s1_Y0_const", start_offsetY[0], 312);
    chk("s1_X1_const", start_offsetX[1], 156);

    // Consecutive fill continues the stream
    fill_and_check("s1b");

    // Scenario 2: wrap on X, no wrap on Y
    load_seed(16'h03E0);
    fill_and_check("s2");
    chk("s2_X0_const", start_offsetX[0], 16);
    chk("s2_Y0_const", start_offsetY[0], 248);

    // Scenario 3: zero seed substitutes SEED
    load_seed(16'h0000);
    fill_and_check("s3");
    chk("s3_X0_const", start_offsetX[0], 112);
    chk("s3_Y0_const", start_offsetY[0], 312);

    // Scenario 4: abort after five writes
    model_fill(5);
    m_lfsr = 16'h1234;
    sb.push_back('{x: m_x, y: m_y});
    regen_req = 1'b1;
    tick;
    regen_req = 1'b0;
    repeat (5) tick;
    chk("s4_busy_pre", int'(busy), 1);
    seed_load = 1'b1; seed_in = 16'h1234;
    tick;
    seed_load = 1'b0;
    chk("s4_busy_post", int'(busy), 0);
    nd = 0;
    repeat (6) begin
      if (done || busy) nd++;
      tick;
    end
    chk("s4_no_done", nd, 0);
    cmp_table("s4");
    fill_and_check("s4b");

    // seed_load and regen_req together: seed wins, no fill
    seed_load = 1'b1; regen_req = 1'b1; seed_in = 16'h03E0;
    tick;
    seed_load = 1'b0; regen_req = 1'b0;
    m_lfsr = 16'h03E0;
    chk("col_busy0", int'(busy), 0);
    tick;
    chk("col_busy1", int'(busy), 0);
    fill_and_check("col");
    chk("col_X0_const", start_offsetX[0], 16);

    // Scenario 5: regen_req held high, back-to-back fills
    model_fill(2*N); sb.push_back('{x: m_x, y: m_y});
    model_fill(2*N); sb.push_back('{x: m_x, y: m_y});
    regen_req = 1'b1;
    tick;
    nd = 0; nb = 0; c1 = 0; c2 = 0;
    for (int c = 0; c < 200; c++) begin
      if (done) begin
        nd++;
        cmp_table($sformatf("s5_%0d", nd));
        if (nd == 1) c1 = c;
        else begin c2 = c; regen_req = 1'b0; break; end
      end
      if (busy) nb++;
      tick;
    end
    regen_req = 1'b0;
    chk("s5_ndone", nd, 2);
    chk("s5_busy_total", nb, 4*N);
    chk("s5_period", c2 - c1, 2*N + 2);
    tick;
    chk("s5_idle_done", int'(done), 0);
    tick;
    chk("s5_no_refill", int'(busy), 0);

    // Reset mid-fill clears everything, then idle gap does not disturb the LFSR
    regen_req = 1'b1;
    tick;
    regen_req = 1'b0;
    repeat (3) tick;
    RESET = 1'b1;
    tick;
    RESET = 1'b0;
    model_reset();
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_done", int'(done), 0);
    chk("mrst_X0", start_offsetX[0], 0);
    chk("mrst_Y0", start_offsetY[0], 0);
    nd = 0;
    repeat (10) begin
      if (done || busy) nd++;
      tick;
    end
    chk("mrst_quiet", nd, 0);
    fill_and_check("s6");
    chk("s6_X0_const", start_offsetX[0], 112);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
